// File: rtl/md_if.sv
// md_if: handshake/result bundle between the EX stage and the multiply/divide unit.
//   master : drives start, md_op, src_a, src_b; observes busy, stall_req, hi, lo
//   slave  : the md_unit side of the same signals
interface md_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       md_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, src_a, src_b,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the architectural HI/LO pair.
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous, active-high; aborts any operation in flight
//   md    : md_if.slave -- start/md_op/src_a/src_b in; busy, stall_req, hi, lo out
// The full result is computed in the accept cycle and parked in shadow registers;
// a down-counter then models the operation latency and commits on terminal count.
// Optional build macro MD_UNIT_MADD_EN adds madd (7), maddu (8) and msub (9).
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no operation in flight; accepts mul/div/mthi/mtlo
//   RUN   | counting down; commits shadow to hi/lo when counter hits 1
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic clk,
    input logic reset,
    md_if.slave md
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_UNIT_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
`endif

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] shadow_hi;
    logic [WIDTH-1:0] shadow_lo;
    logic             shadow_commit;

    logic                 is_mul;
    logic                 is_div;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   prod_u;
    logic                 div_zero;
    logic                 div_ovf;
    logic [WIDTH-1:0]     b_safe;
    logic [WIDTH-1:0]     quo_s;
    logic [WIDTH-1:0]     rem_s;
    logic [WIDTH-1:0]     quo_u;
    logic [WIDTH-1:0]     rem_u;
    logic [2*WIDTH-1:0]   res_next;
    logic                 commit_next;

    always_comb begin
        is_mul = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);
`ifdef MD_UNIT_MADD_EN
        is_mul = is_mul || (md.md_op == OP_MADD) || (md.md_op == OP_MADDU) ||
                 (md.md_op == OP_MSUB);
`endif
        is_div = (md.md_op == OP_DIV) || (md.md_op == OP_DIVU);
    end

    // Both products taken at 2*WIDTH: sign-extending first makes the low 2*WIDTH
    // bits of the unsigned multiply equal the signed product.
    assign prod_s = {{WIDTH{md.src_a[WIDTH-1]}}, md.src_a} *
                    {{WIDTH{md.src_b[WIDTH-1]}}, md.src_b};
    assign prod_u = {{WIDTH{1'b0}}, md.src_a} * {{WIDTH{1'b0}}, md.src_b};

    // Zero divisor and most-negative / -1 are resolved outside the divider, so
    // the divider is fed a harmless divisor of 1 in those cases.
    assign div_zero = (md.src_b == '0);
    assign div_ovf  = (md.src_a == MOST_NEG) && (md.src_b == {WIDTH{1'b1}});
    assign b_safe   = (div_zero || div_ovf) ? {{(WIDTH-1){1'b0}}, 1'b1} : md.src_b;
    assign quo_s    = $signed(md.src_a) / $signed(b_safe);
    assign rem_s    = $signed(md.src_a) % $signed(b_safe);
    assign quo_u    = md.src_a / b_safe;
    assign rem_u    = md.src_a % b_safe;

    always_comb begin
        res_next    = '0;
        commit_next = 1'b1;
        case (md.md_op)
            OP_MULT:  res_next = prod_s;
            OP_MULTU: res_next = prod_u;
            OP_DIV: begin
                if (div_zero)     commit_next = 1'b0;
                else if (div_ovf) res_next = {{WIDTH{1'b0}}, MOST_NEG};
                else              res_next = {rem_s, quo_s};
            end
            OP_DIVU: begin
                if (div_zero) commit_next = 1'b0;
                else          res_next = {rem_u, quo_u};
            end
`ifdef MD_UNIT_MADD_EN
            OP_MADD:  res_next = {hi_q, lo_q} + prod_s;
            OP_MADDU: res_next = {hi_q, lo_q} + prod_u;
            OP_MSUB:  res_next = {hi_q, lo_q} - prod_s;
`endif
            default:  res_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            busy_q        <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            shadow_hi     <= '0;
            shadow_lo     <= '0;
            shadow_commit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md.start) begin
                        if (is_mul || is_div) begin
                            {shadow_hi, shadow_lo} <= res_next;
                            shadow_commit <= commit_next;
                            cnt    <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            busy_q <= 1'b1;
                            state  <= ST_RUN;
                        end else if (md.md_op == OP_MTHI) begin
                            hi_q <= md.src_a;
                        end else if (md.md_op == OP_MTLO) begin
                            lo_q <= md.src_a;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        if (shadow_commit) begin
                            hi_q <= shadow_hi;
                            lo_q <= shadow_lo;
                        end
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign md.busy      = busy_q;
    assign md.stall_req = busy_q || (md.start && (is_mul || is_div));
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed and randomized checks of md_unit against an arithmetic
// reference of HI/LO built from 64-bit integer math.
module tb_md_unit;
    localparam int W      = 32;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    logic [W-1:0] ref_hi;
    logic [W-1:0] ref_lo;

    md_if #(.WIDTH(W)) bus ();

    md_unit #(.WIDTH(W), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_muldiv(input logic [3:0] op);
`ifdef MD_UNIT_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd9);
`else
        return (op >= 4'd1 && op <= 4'd4);
`endif
    endfunction

    // Applies the architectural effect of one accepted operation to ref_hi/ref_lo.
    task automatic model_apply(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint        sa, sb, q, r;
        logic [63:0]   acc, pu, ps;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ps  = 64'(sa * sb);
        pu  = {32'b0, a} * {32'b0, b};
        acc = {ref_hi, ref_lo};
        case (op)
            4'd1: {ref_hi, ref_lo} = ps;
            4'd2: {ref_hi, ref_lo} = pu;
            4'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    ref_lo = 32'h8000_0000;
                    ref_hi = 32'h0;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    ref_lo = q[31:0];
                    ref_hi = r[31:0];
                end
            end
            4'd4: if (b != 0) begin
                ref_lo = a / b;
                ref_hi = a % b;
            end
            4'd5: ref_hi = a;
            4'd6: ref_lo = a;
`ifdef MD_UNIT_MADD_EN
            4'd7: {ref_hi, ref_lo} = acc + ps;
            4'd8: {ref_hi, ref_lo} = acc + pu;
            4'd9: {ref_hi, ref_lo} = acc - ps;
`endif
            default: ;
        endcase
    endtask

    // Issues one op from IDLE; optionally injects a second mult start at busy cycle inj_at.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inj_at);
        int n;
        int exp_cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = op;
        bus.src_a = a;
        bus.src_b = b;
        #1;
        check({tag, ".stall_req"}, 64'(bus.stall_req), 64'(is_muldiv(op)));
        exp_cyc = !is_muldiv(op) ? 0 : ((op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N);
        model_apply(op, a, b);
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            if (n == inj_at) begin
                bus.start = 1'b1;
                bus.md_op = 4'd1;
                bus.src_a = $urandom;
                bus.src_b = $urandom;
                #1;
                check({tag, ".stall_busy"}, 64'(bus.stall_req), 64'd1);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, ".busy_cycles"}, 64'(n), 64'(exp_cyc));
        check({tag, ".hi"}, 64'(bus.hi), 64'(ref_hi));
        check({tag, ".lo"}, 64'(bus.lo), 64'(ref_lo));
    endtask

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [W-1:0] specials [6];
        vectors     = 0;
        miscompares = 0;
        ref_hi      = '0;
        ref_lo      = '0;
        specials    = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        bus.start   = 1'b0;
        bus.md_op   = 4'd0;
        bus.src_a   = '0;
        bus.src_b   = '0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.stall", 64'(bus.stall_req), 64'd0);
        check("reset.hi", 64'(bus.hi), 64'd0);
        check("reset.lo", 64'(bus.lo), 64'd0);

        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 0);
        check("mult.hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
        check("mult.lo_const", 64'(bus.lo), 64'hFFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 0);
        check("multu.hi_const", 64'(bus.hi), 64'h1);
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
        check("div.lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
        check("div.hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
        run_op("divu0", 4'd4, 32'd7, 32'd0, 0);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // mthi then mtlo on back-to-back cycles
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 4'd5; bus.src_a = 32'h1234_5678;
        model_apply(4'd5, 32'h1234_5678, 32'h0);
        @(negedge clk);
        bus.md_op = 4'd6; bus.src_a = 32'h9ABC_DEF0;
        check("mthi.hi", 64'(bus.hi), 64'(ref_hi));
        check("mthi.busy", 64'(bus.busy), 64'd0);
        model_apply(4'd6, 32'h9ABC_DEF0, 32'h0);
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo.lo", 64'(bus.lo), 64'(ref_lo));
        check("mtlo.busy", 64'(bus.busy), 64'd0);

        run_op("mult_inj", 4'd1, 32'h0001_0003, 32'hFFFF_0005, 3);

        // reset during busy cycle 3 of a div: no commit afterwards
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = 4'd4; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ref_hi = '0; ref_lo = '0;
        check("rst_mid.busy", 64'(bus.busy), 64'd0);
        check("rst_mid.hi", 64'(bus.hi), 64'd0);
        check("rst_mid.lo", 64'(bus.lo), 64'd0);
        repeat (DIV_N) @(negedge clk);
        check("rst_mid.no_commit", {bus.hi, bus.lo}, 64'd0);
        check("rst_mid.busy_late", 64'(bus.busy), 64'd0);

`ifdef MD_UNIT_MADD_EN
        run_op("m_hi0", 4'd5, 32'h0, 32'h0, 0);
        run_op("m_lo1", 4'd6, 32'hFFFF_FFFF, 32'h0, 0);
        run_op("maddu", 4'd8, 32'd1, 32'd1, 0);
        check("maddu.hi_const", 64'(bus.hi), 64'h1);
        check("maddu.lo_const", 64'(bus.lo), 64'h0);
        run_op("m_hi0b", 4'd5, 32'h0, 32'h0, 0);
        run_op("m_lo0b", 4'd6, 32'h0, 32'h0, 0);
        run_op("msub", 4'd9, 32'd1, 32'd2, 0);
        check("msub.hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
        check("msub.lo_const", 64'(bus.lo), 64'hFFFF_FFFE);
`endif

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : W'($urandom);
            run_op("rand", op, a, b, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
